// File: rtl/reservation_station_pkg.sv
// Purpose: shared types and widths for the dual-issue reservation station.
// Latency: not applicable (types, constants and pure helper functions only).
// Backpressure: not applicable.
// Contents: instr_type_t / instr_name_t encodings, instr_info_t (issue payload),
//           exec_info_t (dispatch payload), rs_entry_t (stored entry), and
//           conversions between them.
package reservation_station_pkg;

  localparam int XLEN    = 32;
  localparam int TAG_W   = 6;
  localparam int FLAGS_W = 4;

  // Functional-unit class an instruction is steered to.
  typedef enum logic [2:0] {
    AL = 3'd0,
    BR = 3'd1,
    LS = 3'd2,
    RB = 3'd3,
    MD = 3'd4
  } instr_type_t;

  // UNKNOWN marks an empty issue slot.
  typedef enum logic [4:0] {
    UNKNOWN = 5'd0,
    ADD, SUB, AND_OP, OR_OP, XOR_OP, SLL, SRL, SRA, SLT, LUI,
    BEQ, BNE, JAL, LW, SW, MUL, DIV
  } instr_name_t;

  // Payload carried by each issue slot.
  typedef struct packed {
    logic [XLEN-1:0]    address;
    logic [XLEN-1:0]    immediate;
    instr_name_t        instr_name;
    instr_type_t        instr_type;
    logic [TAG_W-1:0]   src1_tag;
    logic [TAG_W-1:0]   src2_tag;
    logic [XLEN-1:0]    src1_data;
    logic [XLEN-1:0]    src2_data;
    logic               src1_valid;
    logic               src2_valid;
    logic [TAG_W-1:0]   dest_tag;
    logic [FLAGS_W-1:0] flags;
  } instr_info_t;

  // Payload handed to the execution unit.
  typedef struct packed {
    instr_name_t        instr_name;
    logic [XLEN-1:0]    address;
    logic [XLEN-1:0]    immediate;
    logic [XLEN-1:0]    src1_data;
    logic [XLEN-1:0]    src2_data;
    logic [TAG_W-1:0]   dest_tag;
    logic [FLAGS_W-1:0] flags;
  } exec_info_t;

  // What a station entry actually keeps; instr_type is implied by the station.
  typedef struct packed {
    instr_name_t        instr_name;
    logic [XLEN-1:0]    address;
    logic [XLEN-1:0]    immediate;
    logic [TAG_W-1:0]   src1_tag;
    logic               src1_valid;
    logic [XLEN-1:0]    src1_data;
    logic [TAG_W-1:0]   src2_tag;
    logic               src2_valid;
    logic [XLEN-1:0]    src2_data;
    logic [TAG_W-1:0]   dest_tag;
    logic [FLAGS_W-1:0] flags;
  } rs_entry_t;

  function automatic rs_entry_t to_entry(input instr_info_t i);
    rs_entry_t e;
    e.instr_name = i.instr_name;
    e.address    = i.address;
    e.immediate  = i.immediate;
    e.src1_tag   = i.src1_tag;
    e.src1_valid = i.src1_valid;
    e.src1_data  = i.src1_data;
    e.src2_tag   = i.src2_tag;
    e.src2_valid = i.src2_valid;
    e.src2_data  = i.src2_data;
    e.dest_tag   = i.dest_tag;
    e.flags      = i.flags;
    return e;
  endfunction

  function automatic exec_info_t to_exec(input rs_entry_t e);
    exec_info_t x;
    x.instr_name = e.instr_name;
    x.address    = e.address;
    x.immediate  = e.immediate;
    x.src1_data  = e.src1_data;
    x.src2_data  = e.src2_data;
    x.dest_tag   = e.dest_tag;
    x.flags      = e.flags;
    return x;
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Purpose: lowest-index priority encoder over an N-bit request vector.
// Latency: purely combinational.
// Backpressure: none.
// Ports: req   - request vector, bit i set means index i is a candidate
//        idx   - lowest set index (0 when nothing is set)
//        found - at least one request bit is set
module rs_select
  import reservation_station_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Purpose: dual-issue reservation station; holds instructions until both operands
//          are captured from the CDB, then dispatches the lowest-index ready entry.
// Latency: an entry written with both operands valid is presented the next cycle.
// Backpressure: exec_ready low holds the presented entry in place; full (registered)
//               rises when fewer than two entries would be free.
// Ports: clock/reset/flush        - clock, sync active-high reset, sync mispredict clear
//        in_valid[2], in_info[2]  - two issue slots; only STATION-type slots allocate
//        cdb_valid/tag/data[2]    - two result broadcast buses, bus 0 has priority
//        exec_valid/ready/info    - dispatch handshake toward the execution unit
//        full                     - tells the issuer to stop presenting instructions
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int          XLEN    = reservation_station_pkg::XLEN,
  parameter int          SIZE    = 8,
  parameter int          TAG_W   = reservation_station_pkg::TAG_W,
  parameter instr_type_t STATION = AL
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [1:0]            in_valid,
  input  instr_info_t [1:0]     in_info,
  input  logic [1:0]            cdb_valid,
  input  logic [1:0][TAG_W-1:0] cdb_tag,
  input  logic [1:0][XLEN-1:0]  cdb_data,
  output logic                  exec_valid,
  input  logic                  exec_ready,
  output exec_info_t            exec_info,
  output logic                  full
);

  localparam int IDX_W = $clog2(SIZE);
  localparam int CNT_W = $clog2(SIZE) + 1;

  // State
  logic [SIZE-1:0]  valid_q, valid_d;
  rs_entry_t        entry_q [SIZE];
  rs_entry_t        entry_d [SIZE];
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  // Search vectors and encoder results
  logic [SIZE-1:0]  free_vec;
  logic [SIZE-1:0]  free_vec_2nd;
  logic [SIZE-1:0]  ready_vec;
  logic [IDX_W-1:0] free_idx_a, free_idx_b, sel_idx;
  logic             free_found_a, free_found_b, sel_found;

  // Allocation decisions
  logic [1:0]       alloc_want;
  logic             alloc0, alloc1;
  logic [IDX_W-1:0] alloc1_idx;
  logic             fire;

  // Operand wake-up: a waiting operand takes the broadcast whose tag matches,
  // bus 0 checked first so it wins when both buses carry the same tag.
  function automatic rs_entry_t snoop(
    input rs_entry_t             e,
    input logic [1:0]            cv,
    input logic [1:0][TAG_W-1:0] ct,
    input logic [1:0][XLEN-1:0]  cd
  );
    rs_entry_t r;
    r = e;
    if (!e.src1_valid) begin
      if (cv[0] && (ct[0] == e.src1_tag)) begin
        r.src1_valid = 1'b1;
        r.src1_data  = cd[0];
      end else if (cv[1] && (ct[1] == e.src1_tag)) begin
        r.src1_valid = 1'b1;
        r.src1_data  = cd[1];
      end
    end
    if (!e.src2_valid) begin
      if (cv[0] && (ct[0] == e.src2_tag)) begin
        r.src2_valid = 1'b1;
        r.src2_data  = cd[0];
      end else if (cv[1] && (ct[1] == e.src2_tag)) begin
        r.src2_valid = 1'b1;
        r.src2_data  = cd[1];
      end
    end
    return r;
  endfunction

  // Free search uses the occupancy at the start of the cycle, so an entry being
  // dispatched this cycle only becomes allocatable from the next one.
  always_comb begin
    free_vec                 = ~valid_q;
    free_vec_2nd             = free_vec;
    free_vec_2nd[free_idx_a] = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      ready_vec[i] = valid_q[i] & entry_q[i].src1_valid & entry_q[i].src2_valid;
    end
  end

  rs_select #(.N(SIZE), .IDX_W(IDX_W)) u_free_a (
    .req   (free_vec),
    .idx   (free_idx_a),
    .found (free_found_a)
  );

  rs_select #(.N(SIZE), .IDX_W(IDX_W)) u_free_b (
    .req   (free_vec_2nd),
    .idx   (free_idx_b),
    .found (free_found_b)
  );

  rs_select #(.N(SIZE), .IDX_W(IDX_W)) u_ready (
    .req   (ready_vec),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Slot 0 takes the lowest free entry; slot 1 takes the next one if slot 0
  // used the first, otherwise the first. A slot with no free entry is dropped.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      alloc_want[s] = in_valid[s] && (in_info[s].instr_type == STATION);
    end
    alloc0     = alloc_want[0] && free_found_a;
    alloc1     = alloc_want[1] && (alloc0 ? free_found_b : free_found_a);
    alloc1_idx = alloc0 ? free_idx_b : free_idx_a;
    fire       = sel_found && exec_ready;
  end

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    count_d = count_q;

    // Snooping free entries is harmless: their contents are overwritten on
    // allocation and never observed before that.
    for (int i = 0; i < SIZE; i++) begin
      entry_d[i] = snoop(entry_q[i], cdb_valid, cdb_tag, cdb_data);
    end

    if (fire) begin
      valid_d[sel_idx] = 1'b0;
    end

    // Incoming operands also see this cycle's broadcasts (bypass).
    if (alloc0) begin
      valid_d[free_idx_a] = 1'b1;
      entry_d[free_idx_a] = snoop(to_entry(in_info[0]), cdb_valid, cdb_tag, cdb_data);
    end
    if (alloc1) begin
      valid_d[alloc1_idx] = 1'b1;
      entry_d[alloc1_idx] = snoop(to_entry(in_info[1]), cdb_valid, cdb_tag, cdb_data);
    end

    count_d = count_q + CNT_W'(alloc0) + CNT_W'(alloc1) - CNT_W'(fire);

    // Mispredict clear overrides every other update in the same cycle.
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end

    full_d = (count_d > CNT_W'(SIZE - 2));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Payload storage needs no reset: it is only visible through a valid bit.
  always_ff @(posedge clock) begin
    entry_q <= entry_d;
  end

  // Zero payload when nothing is presented keeps the bus quiet after reset.
  always_comb begin
    exec_valid = sel_found;
    exec_info  = '0;
    if (sel_found) begin
      exec_info = to_exec(entry_q[sel_idx]);
    end
    full = full_q;
  end

endmodule

// File: tb/tb_reservation_station.sv
// Purpose: self-checking bench for reservation_station (vector table, corner sequences, random run).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exec_ready driven from the table or randomly; issuer honours full in random mode.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int SIZE = 8;

  logic                  clock = 1'b0;
  logic                  reset, flush;
  logic [1:0]            in_valid;
  instr_info_t [1:0]     in_info;
  logic [1:0]            cdb_valid;
  logic [1:0][5:0]       cdb_tag;
  logic [1:0][31:0]      cdb_data;
  logic                  exec_valid, exec_ready, full;
  exec_info_t            exec_info;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which entries are occupied and what each one holds.
  logic        m_occ [SIZE];
  instr_info_t m_ent [SIZE];
  logic        m_full;

  always #5 clock = ~clock;

  reservation_station #(.XLEN(32), .SIZE(SIZE), .TAG_W(6), .STATION(AL)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_info    (in_info),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .exec_valid (exec_valid),
    .exec_ready (exec_ready),
    .exec_info  (exec_info),
    .full       (full)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic instr_info_t mk(input instr_type_t ty, input logic [5:0] t1, input logic v1,
                                     input logic [31:0] d1, input logic [5:0] t2, input logic v2,
                                     input logic [31:0] d2);
    instr_info_t r;
    r            = '0;
    r.instr_name = ADD;
    r.instr_type = ty;
    r.src1_tag   = t1;
    r.src1_valid = v1;
    r.src1_data  = d1;
    r.src2_tag   = t2;
    r.src2_valid = v2;
    r.src2_data  = d2;
    r.address    = d1 ^ 32'h0000_1000;
    r.immediate  = d2 + 32'd1;
    r.dest_tag   = t1 ^ t2;
    r.flags      = d1[3:0];
    return r;
  endfunction

  // Operand capture rule: bus 0 first, then bus 1, only for operands still waiting.
  function automatic instr_info_t wake(input instr_info_t e);
    instr_info_t r;
    r = e;
    if (!e.src1_valid) begin
      if (cdb_valid[0] && cdb_tag[0] == e.src1_tag) begin r.src1_valid = 1'b1; r.src1_data = cdb_data[0]; end
      else if (cdb_valid[1] && cdb_tag[1] == e.src1_tag) begin r.src1_valid = 1'b1; r.src1_data = cdb_data[1]; end
    end
    if (!e.src2_valid) begin
      if (cdb_valid[0] && cdb_tag[0] == e.src2_tag) begin r.src2_valid = 1'b1; r.src2_data = cdb_data[0]; end
      else if (cdb_valid[1] && cdb_tag[1] == e.src2_tag) begin r.src2_valid = 1'b1; r.src2_data = cdb_data[1]; end
    end
    return r;
  endfunction

  function automatic int ready_index();
    for (int i = 0; i < SIZE; i++) begin
      if (m_occ[i] && m_ent[i].src1_valid && m_ent[i].src2_valid) return i;
    end
    return -1;
  endfunction

  task automatic model_edge();
    instr_info_t nent [SIZE];
    logic        nocc [SIZE];
    logic        taken [SIZE];
    logic        placed;
    int          sel;
    int          cnt;
    if (reset || flush) begin
      for (int i = 0; i < SIZE; i++) m_occ[i] = 1'b0;
      m_full = 1'b0;
      return;
    end
    sel = ready_index();
    for (int i = 0; i < SIZE; i++) begin
      nocc[i]  = m_occ[i];
      taken[i] = m_occ[i];
      nent[i]  = m_occ[i] ? wake(m_ent[i]) : m_ent[i];
    end
    if (sel >= 0 && exec_ready) nocc[sel] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (in_valid[s] && in_info[s].instr_type == AL) begin
        placed = 1'b0;
        for (int j = 0; j < SIZE; j++) begin
          if (!placed && !taken[j]) begin
            placed   = 1'b1;
            taken[j] = 1'b1;
            nocc[j]  = 1'b1;
            nent[j]  = wake(in_info[s]);
          end
        end
      end
    end
    cnt = 0;
    for (int i = 0; i < SIZE; i++) begin
      m_occ[i] = nocc[i];
      m_ent[i] = nent[i];
      if (nocc[i]) cnt++;
    end
    m_full = (cnt > SIZE - 2);
  endtask

  task automatic check_model();
    int         s;
    exec_info_t e;
    s = ready_index();
    e = '0;
    if (s >= 0) begin
      e.instr_name = m_ent[s].instr_name;
      e.address    = m_ent[s].address;
      e.immediate  = m_ent[s].immediate;
      e.src1_data  = m_ent[s].src1_data;
      e.src2_data  = m_ent[s].src2_data;
      e.dest_tag   = m_ent[s].dest_tag;
      e.flags      = m_ent[s].flags;
    end
    chk("model_exec_valid", 256'(exec_valid), 256'(s >= 0));
    chk("model_exec_info", 256'(exec_info), 256'(e));
    chk("model_full", 256'(full), 256'(m_full));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check_model();
  endtask

  task automatic idle();
    reset      = 1'b0;
    flush      = 1'b0;
    in_valid   = 2'b00;
    in_info    = '0;
    cdb_valid  = 2'b00;
    cdb_tag    = '0;
    cdb_data   = '0;
    exec_ready = 1'b0;
  endtask

  typedef struct {
    logic        rst, fl;
    logic [1:0]  iv;
    instr_info_t i0, i1;
    logic        er;
    logic [1:0]  cv;
    logic [5:0]  ct0, ct1;
    logic [31:0] cd0, cd1;
    logic        ev;
    logic [31:0] es1, es2;
    logic        ef;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic rst, input logic fl, input logic [1:0] iv, input instr_info_t i0,
                     input instr_info_t i1, input logic er, input logic [1:0] cv,
                     input logic [5:0] ct0, input logic [31:0] cd0, input logic [5:0] ct1,
                     input logic [31:0] cd1, input logic ev, input logic [31:0] es1,
                     input logic [31:0] es2, input logic ef);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.i0 = i0; v.i1 = i1; v.er = er; v.cv = cv;
    v.ct0 = ct0; v.cd0 = cd0; v.ct1 = ct1; v.cd1 = cd1;
    v.ev = ev; v.es1 = es1; v.es2 = es2; v.ef = ef;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_info_t z;
    int          ndisp;
    z = '0;
    idle();

    // ---------------- table-driven vectors ----------------
    add(1'b1,1'b0,2'b00,z,z,1'b0,2'b00,6'd0,32'h0,6'd0,32'h0, 1'b0,32'h0,32'h0,1'b0);
    add(1'b0,1'b0,2'b11,mk(AL,6'd0,1'b1,32'h11,6'd0,1'b1,32'h12),mk(AL,6'd0,1'b1,32'h21,6'd0,1'b1,32'h22),
        1'b0,2'b00,6'd0,32'h0,6'd0,32'h0, 1'b1,32'h11,32'h12,1'b0);
    add(1'b0,1'b0,2'b00,z,z,1'b1,2'b00,6'd0,32'h0,6'd0,32'h0, 1'b1,32'h21,32'h22,1'b0);
    add(1'b0,1'b0,2'b00,z,z,1'b1,2'b00,6'd0,32'h0,6'd0,32'h0, 1'b0,32'h0,32'h0,1'b0);
    add(1'b0,1'b0,2'b01,mk(AL,6'd5,1'b0,32'h0,6'd0,1'b1,32'h77),z,1'b0,2'b00,6'd0,32'h0,6'd0,32'h0, 1'b0,32'h0,32'h0,1'b0);
    add(1'b0,1'b0,2'b00,z,z,1'b0,2'b00,6'd0,32'h0,6'd0,32'h0, 1'b0,32'h0,32'h0,1'b0);
    add(1'b0,1'b0,2'b00,z,z,1'b0,2'b01,6'd5,32'hDEADBEEF,6'd0,32'h0, 1'b1,32'hDEADBEEF,32'h77,1'b0);
    add(1'b0,1'b0,2'b00,z,z,1'b1,2'b00,6'd0,32'h0,6'd0,32'h0, 1'b0,32'h0,32'h0,1'b0);
    add(1'b0,1'b0,2'b01,mk(AL,6'd0,1'b1,32'h33,6'd9,1'b0,32'h0),z,1'b0,2'b10,6'd0,32'h0,6'd9,32'h12, 1'b1,32'h33,32'h12,1'b0);
    add(1'b0,1'b0,2'b00,z,z,1'b1,2'b00,6'd0,32'h0,6'd0,32'h0, 1'b0,32'h0,32'h0,1'b0);
    add(1'b0,1'b0,2'b01,mk(AL,6'd3,1'b0,32'h0,6'd0,1'b1,32'h44),z,1'b0,2'b00,6'd0,32'h0,6'd0,32'h0, 1'b0,32'h0,32'h0,1'b0);
    add(1'b0,1'b0,2'b00,z,z,1'b0,2'b11,6'd3,32'h1,6'd3,32'h2, 1'b1,32'h1,32'h44,1'b0);
    add(1'b0,1'b0,2'b00,z,z,1'b1,2'b00,6'd0,32'h0,6'd0,32'h0, 1'b0,32'h0,32'h0,1'b0);
    add(1'b0,1'b0,2'b11,mk(BR,6'd0,1'b1,32'h55,6'd0,1'b1,32'h56),mk(LS,6'd0,1'b1,32'h57,6'd0,1'b1,32'h58),
        1'b0,2'b00,6'd0,32'h0,6'd0,32'h0, 1'b0,32'h0,32'h0,1'b0);
    add(1'b0,1'b0,2'b11,mk(AL,6'd0,1'b1,32'h61,6'd0,1'b1,32'h62),mk(AL,6'd0,1'b1,32'h71,6'd0,1'b1,32'h72),
        1'b0,2'b00,6'd0,32'h0,6'd0,32'h0, 1'b1,32'h61,32'h62,1'b0);
    add(1'b1,1'b0,2'b00,z,z,1'b1,2'b00,6'd0,32'h0,6'd0,32'h0, 1'b0,32'h0,32'h0,1'b0);

    for (int r = 0; r < tbl.size(); r++) begin
      reset = tbl[r].rst; flush = tbl[r].fl; in_valid = tbl[r].iv;
      in_info[0] = tbl[r].i0; in_info[1] = tbl[r].i1; exec_ready = tbl[r].er;
      cdb_valid = tbl[r].cv; cdb_tag[0] = tbl[r].ct0; cdb_tag[1] = tbl[r].ct1;
      cdb_data[0] = tbl[r].cd0; cdb_data[1] = tbl[r].cd1;
      tick();
      chk($sformatf("row%0d_exec_valid", r), 256'(exec_valid), 256'(tbl[r].ev));
      chk($sformatf("row%0d_src1", r), 256'(exec_info.src1_data), 256'(tbl[r].es1));
      chk($sformatf("row%0d_src2", r), 256'(exec_info.src2_data), 256'(tbl[r].es2));
      chk($sformatf("row%0d_full", r), 256'(full), 256'(tbl[r].ef));
    end
    idle();

    // ---------------- fill to 7, one dispatch, mixed-type issue ----------------
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid   = 2'b11;
      in_info[0] = mk(AL, 6'd0, 1'b1, 32'h100 + 32'(2*k), 6'd0, 1'b1, 32'h1);
      in_info[1] = mk(AL, 6'd0, 1'b1, 32'h101 + 32'(2*k), 6'd0, 1'b1, 32'h2);
      tick();
    end
    chk("full_at_6", 256'(full), 256'(0));
    in_valid = 2'b01; in_info[0] = mk(AL, 6'd0, 1'b1, 32'h106, 6'd0, 1'b1, 32'h3);
    tick();
    chk("full_at_7", 256'(full), 256'(1));
    in_valid = 2'b00; exec_ready = 1'b1;
    tick();
    chk("full_after_dispatch", 256'(full), 256'(0));
    exec_ready = 1'b0; in_valid = 2'b11;
    in_info[0] = mk(AL, 6'd0, 1'b1, 32'h200, 6'd0, 1'b1, 32'h4);
    in_info[1] = mk(BR, 6'd0, 1'b1, 32'h300, 6'd0, 1'b1, 32'h5);
    tick();
    chk("full_after_mixed_issue", 256'(full), 256'(1));
    in_valid = 2'b00; exec_ready = 1'b1; ndisp = 0;
    for (int c = 0; c < 20 && exec_valid; c++) begin
      ndisp++;
      tick();
    end
    chk("drain_count", 256'(ndisp), 256'(7));
    idle();

    // ---------------- full station, flush, re-allocation from entry 0 ----------------
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid   = 2'b11;
      in_info[0] = mk(AL, 6'd0, 1'b1, 32'h400 + 32'(k), 6'd0, 1'b1, 32'h6);
      in_info[1] = mk(AL, 6'd0, 1'b1, 32'h500 + 32'(k), 6'd0, 1'b1, 32'h7);
      tick();
    end
    chk("full_at_8", 256'(full), 256'(1));
    in_valid = 2'b00; flush = 1'b1; cdb_valid = 2'b01; cdb_tag[0] = 6'd7; cdb_data[0] = 32'h99;
    tick();
    idle();
    chk("flush_exec_valid", 256'(exec_valid), 256'(0));
    chk("flush_full", 256'(full), 256'(0));
    chk("flush_exec_info", 256'(exec_info), 256'(0));
    in_valid = 2'b01; in_info[0] = mk(AL, 6'd7, 1'b0, 32'h0, 6'd0, 1'b1, 32'h8);
    tick();
    in_info[0] = mk(AL, 6'd0, 1'b1, 32'hB0, 6'd0, 1'b1, 32'h9);
    tick();
    chk("second_alloc_presented", 256'(exec_info.src1_data), 256'(32'hB0));
    in_valid = 2'b00; cdb_valid = 2'b01; cdb_tag[0] = 6'd7; cdb_data[0] = 32'hA0;
    tick();
    chk("first_alloc_lowest_index", 256'(exec_info.src1_data), 256'(32'hA0));
    idle();

    // ---------------- randomized run against the model ----------------
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 39) == 0);
      for (int s = 0; s < 2; s++) begin
        in_info[s] = mk(($urandom_range(0, 3) == 0) ? MD : AL,
                        6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                        6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
      end
      in_valid = m_full ? 2'b00 : 2'($urandom_range(0, 3));
      cdb_valid = 2'($urandom_range(0, 3));
      cdb_tag[0] = 6'($urandom_range(0, 7));
      cdb_tag[1] = 6'($urandom_range(0, 7));
      cdb_data[0] = $urandom;
      cdb_data[1] = $urandom;
      exec_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameters, one per line: XLEN, 32, operand/address width; SIZE, 8, entry count (power of two, at least 4); TAG_W, 6, rename tag width; STATION, AL, instr_type value this station accepts.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 flush  in  1  synchronous clear of all entries (mispredict), same effect as reset.
REQ-005 in_valid[2]  in  1 each  issue slot i carries an instruction (instr_name != UNKNOWN).
REQ-006 in_info[2]  in  packed  instr_info_t per slot: address, immediate, instr_name, instr_type, src1/src2 tag, src1/src2 data, src1/src2 valid, dest tag, flags.
REQ-007 cdb_valid[2], cdb_tag[2], cdb_data[2]  in  1/TAG_W/XLEN  two result broadcast buses.
REQ-008 exec_valid  out  1  an entry with both operands ready is presented.
REQ-009 exec_ready  in  1  execution unit accepts the presented entry this cycle.
REQ-010 exec_info  out  packed  exec_info_t: instr_name, address, immediate, src1/src2 data, dest tag, flags.
REQ-011 full  out  1  fullness indication to the issuer; asserted when free entries < 2.

Function
REQ-012 Only slots with in_valid=1 and in_info.instr_type==STATION allocate; all other slots are ignored.
REQ-013 Allocation: slot 0 takes the lowest-index free entry, slot 1 the next free; the written entry is visible from the next cycle.
REQ-014 The upstream stage never presents an allocating slot while full=1; if it does anyway, the excess slot is dropped and entry contents stay unchanged.
REQ-015 Capture: a waiting operand whose tag equals cdb_tag[k] with cdb_valid[k]=1 latches cdb_data[k] and sets its valid bit at the next edge.
REQ-016 Bypass: an operand arriving on an allocating slot with valid=0 and a tag matching a same-cycle CDB broadcast is stored already valid with the CDB data.
REQ-017 If both CDB buses match one operand, bus 0 wins.
REQ-018 Select: exec_valid=1 when any occupied entry has both operands valid. exec_info is driven combinationally from the lowest-index such entry.
REQ-019 Handshake: the entry is freed at the edge where exec_valid and exec_ready are both 1. While exec_valid=1 and exec_ready=0, exec_info holds stable unless a lower-index entry becomes ready.
REQ-020 Minimum latency: allocate at edge N; if both operands are valid at allocation, exec_valid=1 during cycle N+1.
REQ-021 A slot freed at edge N counts toward full at cycle N+1 and is reusable from then. Simultaneous free and allocate in one cycle are legal.
REQ-022 full is registered and derived from the post-update occupancy: asserted at count > SIZE-2, deasserted otherwise.
REQ-023 flush dominates allocation, capture and dispatch in the same cycle.

Reset
REQ-024 On reset or flush: all entries invalid, occupancy 0, full=0, exec_valid=0, exec_info all zeros.
REQ-025 Reset asserted mid-dispatch discards the handshake; no entry survives.

Structure
REQ-026 instr_info_t, exec_info_t, the instr_type encoding (AL, BR, LS, RB, MD) and TAG_W go in the shared structures package.
REQ-027 One sub-module, rs_select: a priority encoder over a SIZE-bit request vector. It returns the lowest set index plus a found flag, and is reused for free-entry search and ready selection.

Verification
REQ-028 Reset, then slots 0 and 1 both AL with all operands valid -> entries 0 and 1 allocated; next cycle exec_valid=1 with entry 0 payload; hold exec_ready=1 -> entry 1 presented the following cycle.
REQ-029 Allocate src1 tag 5 invalid; two cycles later cdb_valid[0]=1, tag 5, data 0xDEADBEEF -> exec_valid=1 the next cycle with src1 data 0xDEADBEEF.
REQ-030 Allocation with src2 tag 9 invalid while CDB bus 1 broadcasts tag 9, data 0x12 in the same cycle -> entry stored ready; exec_valid=1 next cycle with src2 data 0x12.
REQ-031 Fill to 7 entries with exec_ready=0 -> full=1; issue one dispatch -> full=0 the following cycle; slot 0 AL, slot 1 BR -> only slot 0 allocates.
REQ-032 8 ready entries, exec_ready=0, flush=1 for one cycle -> next cycle exec_valid=0, full=0; a new allocation lands in entry 0.
REQ-033 Both CDB buses broadcast tag 3 with data 0x1 and 0x2 onto a waiting operand -> captured value is 0x1.
